// File: rtl/fp_pkg.sv
// Shared opcode/unit definitions for the floating-point co-processor datapath.
package fp_pkg;

  localparam int FP_W = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_SIN = 3'd3,
    OP_COS = 3'd4
  } opcode_t;

  typedef enum logic [1:0] {
    U_ADD  = 2'd0,
    U_MUL  = 2'd1,
    U_TRIG = 2'd2
  } unit_t;

  function automatic logic op_valid(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  // Invalid opcodes map to U_TRIG; callers qualify with op_valid().
  function automatic unit_t unit_of(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB: return U_ADD;
      OP_MUL:         return U_MUL;
      default:        return U_TRIG;
    endcase
  endfunction

endpackage

// File: rtl/order_fifo.sv
// Issue-order queue: power-of-two depth, registered full flag, async active-low reset.
module order_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt, cnt_nx;

  always_comb begin
    cnt_nx = cnt;
    if (push && !pop)
      cnt_nx = cnt + CNT_ONE;
    else if (!push && pop)
      cnt_nx = cnt - CNT_ONE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt  <= cnt_nx;
      full <= (cnt_nx == FULL_CNT);
    end
  end

  // Storage carries data only; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);

endmodule

// File: rtl/result_sequencer.sv
// Retires add/mul/trig results in issue order; optional build macro RESULT_SEQ_BYPASS_EN
// lets a head completion retire straight from the unit inputs, skipping its slot.
module result_sequencer
  import fp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            op_strobe,
  input  logic [2:0]      op_sel,
  input  logic            add_done,
  input  logic            add_overflow,
  input  logic [FP_W-1:0] add_result,
  input  logic            mul_done,
  input  logic            mul_overflow,
  input  logic [FP_W-1:0] mul_result,
  input  logic            sincos_done,
  input  logic [FP_W-1:0] sine_result,
  input  logic [FP_W-1:0] cosine_result,
  output logic [FP_W-1:0] result,
  output logic            done,
  output logic            overflow,
  output logic            out_fifo_hold,
  output logic            add_busy,
  output logic            mul_busy,
  output logic            sine_busy,
  output logic            issue_err
);

  logic [2:0] busy, slot_valid, unit_done;
  logic [2:0] busy_nx, slot_valid_nx, cap, set_vec, clr_vec, byp_vec;
  logic [2:0] head_op;
  unit_t      head_unit, issue_unit;
  logic       full, empty, accept, retire, byp;

  logic [FP_W-1:0] add_res_s, mul_res_s, sin_s, cos_s;
  logic            add_ov_s, mul_ov_s;
  logic [FP_W-1:0] ret_res;
  logic            ret_ov;

  assign unit_done = {sincos_done, mul_done, add_done};

  order_fifo #(.DEPTH(DEPTH), .W(3)) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (accept),
    .pop   (retire),
    .din   (op_sel),
    .head  (head_op),
    .full  (full),
    .empty (empty)
  );

  assign head_unit  = unit_of(head_op);
  assign issue_unit = unit_of(op_sel);

  // Busy and full are the pre-edge values, so an op cannot reissue to a unit retiring this cycle.
  assign accept = op_strobe && op_valid(op_sel) && !full && !busy[issue_unit];

`ifdef RESULT_SEQ_BYPASS_EN
  assign byp = !empty && !slot_valid[head_unit] && unit_done[head_unit];
`else
  assign byp = 1'b0;
`endif

  assign retire  = (!empty && slot_valid[head_unit]) || byp;
  assign byp_vec = byp    ? (3'b001 << head_unit)  : 3'b000;
  assign clr_vec = retire ? (3'b001 << head_unit)  : 3'b000;
  assign set_vec = accept ? (3'b001 << issue_unit) : 3'b000;

  // Capture needs an empty slot; a bypassed completion never lands in its slot.
  assign cap           = unit_done & busy & ~slot_valid & ~byp_vec;
  assign busy_nx       = (busy & ~clr_vec) | set_vec;
  assign slot_valid_nx = (slot_valid & ~clr_vec) | cap;

  always_comb begin
    ret_res = '0;
    ret_ov  = 1'b0;
    case (head_op)
      OP_ADD, OP_SUB: begin
        ret_res = byp ? add_result   : add_res_s;
        ret_ov  = byp ? add_overflow : add_ov_s;
      end
      OP_MUL: begin
        ret_res = byp ? mul_result   : mul_res_s;
        ret_ov  = byp ? mul_overflow : mul_ov_s;
      end
      OP_SIN:  ret_res = byp ? sine_result   : sin_s;
      OP_COS:  ret_res = byp ? cosine_result : cos_s;
      default: ;
    endcase
  end

  // Retire stage boundary: all outputs registered here.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy       <= '0;
      slot_valid <= '0;
      done       <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
      issue_err  <= 1'b0;
    end else begin
      busy       <= busy_nx;
      slot_valid <= slot_valid_nx;
      done       <= retire;
      if (retire) begin
        result   <= ret_res;
        overflow <= ret_ov;
      end
      if (op_strobe && !accept)
        issue_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cap[U_ADD]) begin
      add_res_s <= add_result;
      add_ov_s  <= add_overflow;
    end
    if (cap[U_MUL]) begin
      mul_res_s <= mul_result;
      mul_ov_s  <= mul_overflow;
    end
    if (cap[U_TRIG]) begin
      sin_s <= sine_result;
      cos_s <= cosine_result;
    end
  end

  assign out_fifo_hold = full;
  assign add_busy      = busy[U_ADD];
  assign mul_busy      = busy[U_MUL];
  assign sine_busy     = busy[U_TRIG];

endmodule

// File: tb/tb_result_sequencer.sv
// Directed plus randomized bench for result_sequencer against a queue-based reference model.
module tb_result_sequencer;

  localparam int DEPTH = 2;
`ifdef RESULT_SEQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, n_rst;
  logic        op_strobe;
  logic [2:0]  op_sel;
  logic        add_done, add_overflow, mul_done, mul_overflow, sincos_done;
  logic [31:0] add_result, mul_result, sine_result, cosine_result;
  logic [31:0] result;
  logic        done, overflow, out_fifo_hold, add_busy, mul_busy, sine_busy, issue_err;

  result_sequencer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .op_strobe     (op_strobe),
    .op_sel        (op_sel),
    .add_done      (add_done),
    .add_overflow  (add_overflow),
    .add_result    (add_result),
    .mul_done      (mul_done),
    .mul_overflow  (mul_overflow),
    .mul_result    (mul_result),
    .sincos_done   (sincos_done),
    .sine_result   (sine_result),
    .cosine_result (cosine_result),
    .result        (result),
    .done          (done),
    .overflow      (overflow),
    .out_fifo_hold (out_fifo_hold),
    .add_busy      (add_busy),
    .mul_busy      (mul_busy),
    .sine_busy     (sine_busy),
    .issue_err     (issue_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: the queue holds issued opcodes oldest first; a unit is busy
  // exactly when one of its ops sits in the queue.
  int          mq[$];
  bit          msv[3];
  logic [31:0] mres[3];
  logic [31:0] mcos;
  bit          mov[3];
  logic [31:0] m_result;
  bit          m_done, m_ov, m_err;
  logic [31:0] retired[$];

  function automatic int unit_m(input int op);
    if (op < 2) return 0;
    if (op == 2) return 1;
    return 2;
  endfunction

  function automatic bit busy_m(input int u);
    foreach (mq[i]) if (unit_m(mq[i]) == u) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    mq.delete();
    for (int u = 0; u < 3; u++) msv[u] = 1'b0;
    m_result = '0;
    m_done   = 1'b0;
    m_ov     = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step();
    bit [2:0]    din;
    bit          bz[3];
    bit [2:0]    cap;
    int          hu;
    int          op;
    bit          ret, byp, acc, ov;
    logic [31:0] val;
    din = {sincos_done, mul_done, add_done};
    for (int u = 0; u < 3; u++) bz[u] = busy_m(u);
    hu = -1; ret = 0; byp = 0; val = '0; ov = 0; op = 0;
    if (mq.size() > 0) begin
      hu = unit_m(mq[0]);
      op = mq[0];
      if (msv[hu]) ret = 1;
      else if (BYP && din[hu]) begin ret = 1; byp = 1; end
    end
    if (ret) begin
      case (op)
        0, 1: begin val = byp ? add_result : mres[0]; ov = byp ? add_overflow : mov[0]; end
        2:    begin val = byp ? mul_result : mres[1]; ov = byp ? mul_overflow : mov[1]; end
        3:    begin val = byp ? sine_result : mres[2]; ov = 0; end
        default: begin val = byp ? cosine_result : mcos; ov = 0; end
      endcase
    end
    for (int u = 0; u < 3; u++) cap[u] = din[u] && bz[u] && !msv[u] && !(byp && hu == u);
    acc = op_strobe && (op_sel <= 3'd4) && (mq.size() < DEPTH) && !bz[unit_m(int'(op_sel))];

    m_done = ret;
    if (ret) begin
      m_result = val;
      m_ov     = ov;
      void'(mq.pop_front());
      msv[hu] = 1'b0;
    end
    if (cap[0]) begin mres[0] = add_result; mov[0] = add_overflow; msv[0] = 1; end
    if (cap[1]) begin mres[1] = mul_result; mov[1] = mul_overflow; msv[1] = 1; end
    if (cap[2]) begin mres[2] = sine_result; mcos = cosine_result; msv[2] = 1; end
    if (acc) mq.push_back(int'(op_sel));
    if (op_strobe && !acc) m_err = 1'b1;
  endtask

  task automatic compare_all();
    chk("result",    result,        m_result);
    chk("done",      done,          m_done);
    chk("overflow",  overflow,      m_ov);
    chk("hold",      out_fifo_hold, mq.size() == DEPTH);
    chk("add_busy",  add_busy,      busy_m(0));
    chk("mul_busy",  mul_busy,      busy_m(1));
    chk("sine_busy", sine_busy,     busy_m(2));
    chk("issue_err", issue_err,     m_err);
    if (done) retired.push_back(result);
  endtask

  task automatic idle();
    op_strobe = 0; op_sel = 0;
    add_done = 0; add_overflow = 0; add_result = 0;
    mul_done = 0; mul_overflow = 0; mul_result = 0;
    sincos_done = 0; sine_result = 0; cosine_result = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    idle();
    n_rst = 1'b0;
    #1;
    model_clear();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    n_rst = 1'b1;
  endtask

  task automatic issue(input logic [2:0] op);
    idle();
    op_strobe = 1; op_sel = op;
    step();
    idle();
  endtask

  initial begin
    n_rst = 1'b0;
    idle();
    do_reset();
    chk("rst_result", result, 32'h0);
    chk("rst_hold", out_fifo_hold, 1'b0);

    // Single ADD
    retired.delete();
    issue(3'd0);
    chk("t1_busy", add_busy, 1'b1);
    add_done = 1; add_result = 32'h40400000;
    step();
    idle();
    chk("t1_lat", done, BYP);
    step();
    step();
    chk("t1_count", retired.size(), 1);
    chk("t1_result", result, 32'h40400000);
    chk("t1_ovf", overflow, 1'b0);
    chk("t1_busy_clr", add_busy, 1'b0);

    // MUL then ADD, ADD completes first
    retired.delete();
    issue(3'd2);
    issue(3'd0);
    add_done = 1; add_result = 32'h3F800000;
    step();
    idle();
    step(); step();
    mul_done = 1; mul_result = 32'h40C00000;
    step();
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("t2_count", retired.size(), 2);
    if (retired.size() == 2) begin
      chk("t2_first", retired[0], 32'h40C00000);
      chk("t2_second", retired[1], 32'h3F800000);
    end

    // COS selects cosine
    retired.delete();
    issue(3'd4);
    sincos_done = 1; sine_result = 32'h0; cosine_result = 32'h3F800000;
    step();
    idle();
    step(); step();
    chk("t3_count", retired.size(), 1);
    chk("t3_result", result, 32'h3F800000);
    chk("t3_ovf", overflow, 1'b0);

    // Full queue rejects SIN
    do_reset();
    issue(3'd0);
    issue(3'd2);
    chk("t4_hold", out_fifo_hold, 1'b1);
    issue(3'd3);
    chk("t4_err", issue_err, 1'b1);
    chk("t4_sine_busy", sine_busy, 1'b0);
    add_done = 1; add_result = 32'h11111111;
    mul_done = 1; mul_result = 32'h22222222; mul_overflow = 1;
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    chk("t4_drain", out_fifo_hold, 1'b0);

    // Busy unit and invalid opcode rejected, spurious done ignored
    do_reset();
    issue(3'd0);
    issue(3'd1);
    chk("t5_err", issue_err, 1'b1);
    issue(3'd6);
    chk("t5_hold", out_fifo_hold, 1'b0);
    chk("t5_add_busy", add_busy, 1'b1);
    retired.delete();
    mul_done = 1; mul_result = 32'hDEADBEEF;
    step();
    idle();
    step(); step();
    chk("t5_spurious", retired.size(), 0);
    add_done = 1; add_result = 32'h3F000000;
    step();
    idle();
    step(); step();

    // Reset between issue and completion
    do_reset();
    issue(3'd0);
    do_reset();
    chk("t6_busy", add_busy, 1'b0);
    chk("t6_result", result, 32'h0);
    retired.delete();
    add_done = 1; add_result = 32'h40400000;
    step();
    idle();
    step(); step();
    chk("t6_no_done", retired.size(), 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        op_strobe     = ($urandom_range(0, 2) == 0);
        op_sel        = 3'($urandom_range(0, 7));
        add_done      = ($urandom_range(0, 3) == 0);
        add_overflow  = 1'($urandom_range(0, 1));
        add_result    = $urandom;
        mul_done      = ($urandom_range(0, 3) == 0);
        mul_overflow  = 1'($urandom_range(0, 1));
        mul_result    = $urandom;
        sincos_done   = ($urandom_range(0, 3) == 0);
        sine_result   = $urandom;
        cosine_result = $urandom;
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
